// File: rtl/aes_pkg.sv
// Shared AES-128 key-expansion definitions: forward S-box, round constants,
// word helpers and the key-expander state encoding.
package aes_pkg;

    // Forward S-box, indexed by the input byte
    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // Round constants for rounds 1..10 (most significant byte of the round word)
    localparam logic [7:0] RCON [1:10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    typedef enum logic [1:0] {KX_IDLE, KX_EXPAND, KX_DONE} kx_state_t;

    // Left rotate a word by one byte
    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    // Apply the S-box to every byte of a word
    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational forward S-box lookup for one byte.
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] data,
    output logic [7:0] result
);

    assign result = SBOX[data];

endmodule

// File: rtl/aes_key_expander.sv
// Iterative AES-128 key expansion, one round key per clock.
// KeySchedule slice i holds round key (10-i): the cipher key is in the top
// slice and the last round key in the bottom slice, decryption order.
// Optional build macro AES_KEYEXP_CACHE_EN: remembers the key of the last
// completed expansion and answers a repeat request without re-expanding.
module aes_key_expander
    import aes_pkg::*;
#(
    parameter int NR = 10
) (
    input  logic          clk,
    input  logic          RESET,
    input  logic          start,
    input  logic [127:0]  Cipherkey,
    output logic [1407:0] KeySchedule,
    output logic          ks_valid,
    output logic          busy
);

    if (NR != 10) begin : g_nr_check
        $error("aes_key_expander supports only NR = 10 (AES-128)");
    end

    kx_state_t    state_reg;
    logic [3:0]   rnd_reg;
    logic [127:0] cur_key_reg;
    logic         ks_valid_reg;
    logic         busy_reg;

    logic [31:0]  rot_w;
    logic [31:0]  sub_w;
    logic [31:0]  temp_w;
    logic [7:0]   rcon_byte;
    logic [127:0] next_key;
    logic         cache_hit;
    logic         load_fire;
    logic         exp_fire;

    genvar gi;

    // Round function datapath: four S-box lanes on the rotated last word
    assign rot_w = rot_word(cur_key_reg[31:0]);
    for (gi = 0; gi < 4; gi++) begin : g_sbox
        aes_sbox u_sbox (
            .data   (rot_w[8*gi +: 8]),
            .result (sub_w[8*gi +: 8])
        );
    end

    // Round constant for the round currently being computed
    always_comb begin
        rcon_byte = 8'h00;
        if (rnd_reg >= 4'd1 && rnd_reg <= 4'd10) begin
            rcon_byte = RCON[rnd_reg];
        end
    end

    assign temp_w = sub_w ^ {rcon_byte, 24'h0};
    assign next_key[127:96] = cur_key_reg[127:96] ^ temp_w;
    assign next_key[95:64]  = cur_key_reg[95:64]  ^ next_key[127:96];
    assign next_key[63:32]  = cur_key_reg[63:32]  ^ next_key[95:64];
    assign next_key[31:0]   = cur_key_reg[31:0]   ^ next_key[63:32];

    assign load_fire = (state_reg == KX_IDLE) && start && !cache_hit;
    assign exp_fire  = (state_reg == KX_EXPAND) && start;

    // Schedule storage: one register per slice with its own write enable
    for (gi = 0; gi <= 10; gi++) begin : g_slice
        logic [127:0] slice_reg;
        logic         wr_en;
        logic [127:0] wr_data;

        if (gi == 10) begin : g_key
            assign wr_en   = load_fire;
            assign wr_data = Cipherkey;
        end else begin : g_round
            assign wr_en   = exp_fire && (rnd_reg == 4'(10 - gi));
            assign wr_data = next_key;
        end

        // Capture the slice's round key; aborted runs leave it untouched
        always_ff @(posedge clk) begin
            if (RESET) begin
                slice_reg <= '0;
            end else if (wr_en) begin
                slice_reg <= wr_data;
            end
        end

        assign KeySchedule[128*gi +: 128] = slice_reg;
    end

`ifdef AES_KEYEXP_CACHE_EN
    logic [127:0] cached_key_reg;
    logic         cached_ok_reg;

    assign cache_hit = cached_ok_reg && (Cipherkey == cached_key_reg);

    // Track the key of the last fully completed expansion
    always_ff @(posedge clk) begin
        if (RESET) begin
            cached_ok_reg  <= 1'b0;
            cached_key_reg <= '0;
        end else if (load_fire) begin
            cached_ok_reg <= 1'b0;
        end else if (state_reg == KX_EXPAND && !start) begin
            cached_ok_reg <= 1'b0;
        end else if (exp_fire && rnd_reg == 4'd10) begin
            cached_ok_reg  <= 1'b1;
            cached_key_reg <= KeySchedule[1407:1280];
        end
    end
`else
    assign cache_hit = 1'b0;
`endif

    // Control FSM: accept, iterate ten rounds, hold completion while start stays high
    always_ff @(posedge clk) begin
        if (RESET) begin
            state_reg    <= KX_IDLE;
            rnd_reg      <= 4'd0;
            cur_key_reg  <= '0;
            ks_valid_reg <= 1'b0;
            busy_reg     <= 1'b0;
        end else begin
            case (state_reg)
                KX_IDLE: begin
                    if (start) begin
                        if (cache_hit) begin
                            state_reg    <= KX_DONE;
                            ks_valid_reg <= 1'b1;
                        end else begin
                            cur_key_reg <= Cipherkey;
                            rnd_reg     <= 4'd1;
                            busy_reg    <= 1'b1;
                            state_reg   <= KX_EXPAND;
                        end
                    end
                end
                KX_EXPAND: begin
                    if (!start) begin
                        state_reg <= KX_IDLE;
                        busy_reg  <= 1'b0;
                        rnd_reg   <= 4'd0;
                    end else begin
                        cur_key_reg <= next_key;
                        if (rnd_reg == 4'd10) begin
                            state_reg    <= KX_DONE;
                            busy_reg     <= 1'b0;
                            ks_valid_reg <= 1'b1;
                        end else begin
                            rnd_reg <= rnd_reg + 4'd1;
                        end
                    end
                end
                KX_DONE: begin
                    if (!start) begin
                        state_reg    <= KX_IDLE;
                        ks_valid_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= KX_IDLE;
                end
            endcase
        end
    end

    assign ks_valid = ks_valid_reg;
    assign busy     = busy_reg;

endmodule

// File: tb/tb_aes_key_expander.sv
// Directed bench for aes_key_expander: table of known round keys plus
// hand-written abort, reset, key-change and back-to-back sequences.
module tb_aes_key_expander;

    localparam logic [127:0] K_FIPS = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] K_ZERO = 128'h0;
`ifdef AES_KEYEXP_CACHE_EN
    localparam int REPEAT_LAT = 1;
`else
    localparam int REPEAT_LAT = 11;
`endif

    logic          clk;
    logic          RESET;
    logic          start;
    logic [127:0]  Cipherkey;
    logic [1407:0] KeySchedule;
    logic          ks_valid;
    logic          busy;

    int total;
    int bad;

    typedef struct {
        logic [127:0] key;
        int           rnd;
        logic [127:0] rk;
    } vec_t;

    vec_t vecs [15];

    aes_key_expander #(.NR(10)) dut (
        .clk         (clk),
        .RESET       (RESET),
        .start       (start),
        .Cipherkey   (Cipherkey),
        .KeySchedule (KeySchedule),
        .ks_valid    (ks_valid),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [127:0] get_rk(input int r);
        return KeySchedule[128*(10-r) +: 128];
    endfunction

    task automatic check128(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %032h want %032h", name, act, exp);
        end else begin
            $display("ok   %s: %032h", name, act);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    // Raise start with a key, count edges to ks_valid and busy-high cycles.
    // toggle_at > 0 inverts Cipherkey after that edge to prove it is ignored.
    task automatic run_expand(input logic [127:0] key, input int exp_lat,
                              input int toggle_at, input string tag);
        int  n;
        int  busy_hi;
        bit  seen;
        @(negedge clk);
        Cipherkey = key;
        start     = 1'b1;
        n = 0;
        busy_hi = 0;
        seen = 1'b0;
        while (!seen && n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (ks_valid) seen = 1'b1;
            else if (busy) busy_hi++;
            if (n == toggle_at) Cipherkey = ~key;
        end
        check_int({tag, " latency"}, seen ? n : -1, exp_lat);
        check_int({tag, " busy cycles"}, busy_hi, exp_lat - 1);
    endtask

    // Lower start for one cycle and confirm completion flags drop
    task automatic drop_start(input string tag);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #1;
        check_int({tag, " ks_valid after drop"}, int'(ks_valid), 0);
    endtask

    initial begin
        logic [127:0] cur_key;
        logic [1407:0] snap;
        int seen_valid;

        total = 0;
        bad   = 0;

        vecs[0]  = '{K_FIPS, 0,  128'h2b7e151628aed2a6abf7158809cf4f3c};
        vecs[1]  = '{K_FIPS, 1,  128'ha0fafe1788542cb123a339392a6c7605};
        vecs[2]  = '{K_FIPS, 2,  128'hf2c295f27a96b9435935807a7359f67f};
        vecs[3]  = '{K_FIPS, 3,  128'h3d80477d4716fe3e1e237e446d7a883b};
        vecs[4]  = '{K_FIPS, 4,  128'hef44a541a8525b7fb671253bdb0bad00};
        vecs[5]  = '{K_FIPS, 5,  128'hd4d1c6f87c839d87caf2b8bc11f915bc};
        vecs[6]  = '{K_FIPS, 6,  128'h6d88a37a110b3efddbf98641ca0093fd};
        vecs[7]  = '{K_FIPS, 7,  128'h4e54f70e5f5fc9f384a64fb24ea6dc4f};
        vecs[8]  = '{K_FIPS, 8,  128'head27321b58dbad2312bf5607f8d292f};
        vecs[9]  = '{K_FIPS, 9,  128'hac7766f319fadc2128d12941575c006e};
        vecs[10] = '{K_FIPS, 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
        vecs[11] = '{K_ZERO, 0,  128'h0};
        vecs[12] = '{K_ZERO, 1,  128'h62636363626363636263636362636363};
        vecs[13] = '{K_ZERO, 2,  128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa};
        vecs[14] = '{K_ZERO, 10, 128'hb4ef5bcb3e92e21123e951cf6f8f188e};

        RESET     = 1'b1;
        start     = 1'b0;
        Cipherkey = K_FIPS;
        repeat (2) @(posedge clk);
        #1;
        check_int("reset ks_valid", int'(ks_valid), 0);
        check_int("reset busy", int'(busy), 0);
        check128("reset schedule top", KeySchedule[1407:1280], 128'h0);
        check128("reset schedule bottom", KeySchedule[127:0], 128'h0);
        @(negedge clk);
        RESET = 1'b0;

        // Table: expand each distinct key once, then compare its round keys
        cur_key = K_FIPS;
        for (int i = 0; i < 15; i++) begin
            if (i == 0 || vecs[i].key != cur_key) begin
                if (i != 0) drop_start($sformatf("table %0d", i));
                run_expand(vecs[i].key, 11, 0, $sformatf("table key %0d", i));
                cur_key = vecs[i].key;
            end
            check128($sformatf("vec %0d rk%0d", i, vecs[i].rnd), get_rk(vecs[i].rnd), vecs[i].rk);
        end
        drop_start("table end");

        // Abort: start drops before edge 5, expansion must not complete
        @(negedge clk);
        Cipherkey = K_FIPS;
        start = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #1;
        check_int("abort busy", int'(busy), 0);
        seen_valid = 0;
        repeat (15) begin
            @(posedge clk);
            #1;
            if (ks_valid) seen_valid++;
        end
        check_int("abort ks_valid never", seen_valid, 0);
        check128("abort retains rk3", get_rk(3), 128'h3d80477d4716fe3e1e237e446d7a883b);
        run_expand(K_FIPS, 11, 0, "after abort");
        check128("after abort rk10", get_rk(10), 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        check128("after abort rk5", get_rk(5), 128'hd4d1c6f87c839d87caf2b8bc11f915bc);
        drop_start("after abort");

        // Reset in the middle of an expansion
        @(negedge clk);
        Cipherkey = K_ZERO;
        start = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        RESET = 1'b1;
        @(posedge clk);
        #1;
        check_int("mid reset busy", int'(busy), 0);
        check_int("mid reset ks_valid", int'(ks_valid), 0);
        check128("mid reset schedule top", KeySchedule[1407:1280], 128'h0);
        check128("mid reset schedule rk10", KeySchedule[127:0], 128'h0);
        @(negedge clk);
        RESET = 1'b0;
        start = 1'b0;
        @(posedge clk);

        // Cipherkey changes after acceptance must not affect the result
        run_expand(K_ZERO, 11, 3, "key toggle");
        check128("key toggle rk10", get_rk(10), 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
        check128("key toggle rk0", get_rk(0), K_ZERO);
        drop_start("key toggle");

        // Back-to-back keys with a single low cycle between them
        run_expand(K_FIPS, 11, 0, "b2b first");
        check128("b2b first rk10", get_rk(10), 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        drop_start("b2b first");
        run_expand(K_ZERO, 11, 0, "b2b second");
        check128("b2b second rk1", get_rk(1), 128'h62636363626363636263636362636363);
        check128("b2b second rk10", get_rk(10), 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
        drop_start("b2b second");

        // Repeated key: cached builds answer at once, others re-expand
        run_expand(K_FIPS, 11, 0, "repeat first");
        drop_start("repeat first");
        snap = KeySchedule;
        run_expand(K_FIPS, REPEAT_LAT, 0, "repeat second");
        total++;
        if (KeySchedule !== snap) begin
            bad++;
            $display("FAIL repeat schedule unchanged: got top %032h bottom %032h", KeySchedule[1407:1280], KeySchedule[127:0]);
        end else begin
            $display("ok   repeat schedule unchanged");
        end
        check128("repeat rk10", get_rk(10), 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        drop_start("repeat second");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
